rx_ctrl: RTL and testbench
==========================

Name: rx_ctrl

Overview:
Sequencing controller for the 8-bit async receiver. It drives the receiver enable, detects each completed frame (`rx_ready`), and captures or discards the byte according to `rx_error`. It pulses `rx_data_ack` to return the receiver to idle, then buffers good bytes in a small FIFO with a valid/ready consumer interface. It also keeps saturating error and overflow statistics.

Parameters:
WIDTH, 8, data byte width (matches receiver `rx_po`)
DEPTH, 4, FIFO entries (power of two, >=2)
ERR_CNT_W, 8, width of saturating frame-error counter

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-high reset
en  in  1  block enable; forwarded to receiver
rx_en  out  1  receiver enable (= en, combinational)
rx_ready  in  1  receiver frame-complete flag
rx_error  in  1  receiver framing-error flag, valid while rx_ready=1
rx_po  in  WIDTH  receiver parallel data, valid while rx_ready=1
rx_busy  in  1  receiver mid-frame indicator (status only)
rx_data_ack  out  1  one-cycle acknowledge to receiver
out_data  out  WIDTH  FIFO head byte
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when out_valid=1
fifo_count  out  $clog2(DEPTH)+1  current occupancy
err_count  out  ERR_CNT_W  frames dropped for rx_error, saturating
overflow  out  1  sticky: a good byte was dropped because FIFO full

Behaviour:
- Reset: all outputs 0 except `rx_en` (follows `en`). FSM enters WAIT. FIFO pointers and count are 0. `err_count` and `overflow` are cleared.
- FSM states: WAIT, CAPTURE, ACK, RELEASE.
- WAIT: `rx_ready`=1 sampled at edge N -> CAPTURE.
- CAPTURE (one cycle), action at edge N+1:
  - if `rx_error`: `err_count`+1, saturating at all-ones; byte dropped.
  - else if FIFO not full, or a pop occurs the same cycle: push `rx_po`.
  - else: drop the byte and set `overflow`.
  - Next state ACK. `rx_data_ack` is registered high from edge N+1 to edge N+2.
- ACK: `rx_data_ack` high exactly one cycle -> RELEASE.
- RELEASE: wait for `rx_ready`=0, then go to WAIT. This prevents double capture, because the receiver clears `rx_ready` one cycle after leaving its result state. `rx_data_ack` is low in RELEASE.
- Latency: `rx_ready` rise to `out_valid` rise is 2 edges when the FIFO is empty.
- FIFO:
  - circular buffer; read/write pointers wrap modulo DEPTH.
  - pop when `out_valid` & `out_ready`.
  - simultaneous push+pop leaves count unchanged.
  - `out_data` is invalid (holds last value) when empty.
  - pop when empty is ignored.
- `en`=0: FSM forced to WAIT and `rx_data_ack`=0. FIFO contents, counters and `overflow` are retained. Consumer pops are still honoured.
- `rst` mid-frame, including during ACK: the ack is aborted and the FIFO is flushed next edge. The receiver self-recovers via its own idle path.
- `err_count` never wraps. `overflow` clears only on `rst`.

Optional Feature:
- Macro: RX_CTRL_KEEP_ERR_EN.
- Defined:
  - FIFO entry width is WIDTH+1. Bit WIDTH holds `rx_error`.
  - Errored frames are pushed, not dropped.
  - Extra output `out_err` (1 bit) is the head flag.
  - `err_count` still increments.
- Undefined: errored frames are dropped as above and `out_err` does not exist.

Decomposition:
- Shared package `rx_pkg`:
  - `RX_WIDTH`=8
  - FSM state typedef/localparams (WAIT=0, CAPTURE=1, ACK=2, RELEASE=3)
  - saturating-increment helper function
- Sub-module `rx_fifo`: synchronous circular FIFO parameterised by WIDTH and DEPTH, exposing push, pop, full, empty and count. It is instanced once.
- FSM and statistics stay in `rx_ctrl`.

Test Plan:
- Good frame 0xA5, `out_ready`=0 -> one-cycle `rx_data_ack` 2 edges after `rx_ready`; `out_data`=0xA5, `out_valid`=1, `fifo_count`=1.
- Errored frame (`rx_error`=1, `rx_po`=0x3C) -> `rx_data_ack` pulses, `fifo_count` stays 0, `err_count`=1; with RX_CTRL_KEEP_ERR_EN: `fifo_count`=1, `out_err`=1.
- 5 good frames 0x01..0x05, `out_ready`=0, DEPTH=4 -> `fifo_count`=4, `overflow`=1; pops return 0x01..0x04 in order.
- FIFO full, with a frame arriving in the same cycle as a pop -> byte accepted, `fifo_count` stays 4, `overflow` stays 0.
- `rx_ready` held high 3 extra cycles after ack -> exactly one push; FSM waits in RELEASE until `rx_ready`=0.
- `err_count` preloaded by 255 errored frames, then one more -> stays 0xFF. `rst` asserted during ACK -> `rx_data_ack`=0 next edge, `fifo_count`=0, `err_count`=0.

Source files
------------

// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types, constants and helpers for the rx_ctrl receiver sequencer
//
// Contents:
//   RX_WIDTH   : receiver byte width
//   rx_state_t : sequencer states WAIT/CAPTURE/ACK/RELEASE
//   sat_inc    : saturating increment for counters up to 32 bits wide
package rx_pkg;

    localparam int RX_WIDTH = 8;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } rx_state_t;

    // Increment value, holding at the all-ones value of a width-bit counter.
    // Callers widen their counter to 32 bits and truncate the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = 32'hFFFF_FFFF >> (32 - width);
        return (value == max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - synchronous circular FIFO buffering received bytes
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset (flushes pointers/count)
//   push       : write push_data (ignored when full unless popping in the same cycle)
//   push_data  : entry to write
//   pop        : remove head entry (ignored when empty)
//   pop_data   : head entry; when empty, holds the most recently popped entry
//   full/empty : occupancy flags
//   count      : current occupancy, 0..DEPTH
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] hold_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign do_push  = push && (!full || do_pop);
    assign count    = count_q;
    assign pop_data = empty ? hold_q : mem[rd_ptr];

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rx_ctrl.sv
// rtl/rx_ctrl.sv - sequencing controller for the 8-bit async receiver
//
// Captures each completed receiver frame, acknowledges it, and buffers good
// bytes in a FIFO with a valid/ready consumer side. Keeps a saturating
// frame-error counter and a sticky overflow flag.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en            : block enable (forwarded as rx_en)
//   rx_en         : receiver enable, follows en
//   rx_ready      : receiver frame-complete flag
//   rx_error      : framing error, valid with rx_ready
//   rx_po         : received byte, valid with rx_ready
//   rx_busy       : receiver mid-frame status (not used for sequencing)
//   rx_data_ack   : one-cycle acknowledge returning the receiver to idle
//   out_data      : FIFO head byte
//   out_valid     : FIFO non-empty
//   out_ready     : consumer accepts head
//   fifo_count    : FIFO occupancy
//   err_count     : saturating count of errored frames
//   overflow      : sticky, a good byte was dropped on a full FIFO
//   out_err       : head entry error flag (only with RX_CTRL_KEEP_ERR_EN)
//
// Build option RX_CTRL_KEEP_ERR_EN: errored frames are queued with their
// error flag instead of being dropped.
module rx_ctrl
    import rx_pkg::*;
#(
    parameter int WIDTH     = RX_WIDTH,
    parameter int DEPTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rx_en,
    input  logic                   rx_ready,
    input  logic                   rx_error,
    input  logic [WIDTH-1:0]       rx_po,
    input  logic                   rx_busy,
    output logic                   rx_data_ack,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic                   overflow
`ifdef RX_CTRL_KEEP_ERR_EN
    ,
    output logic                   out_err
`endif
);

`ifdef RX_CTRL_KEEP_ERR_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    rx_state_t     state;
    logic          capture;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [EW-1:0] push_data;
    logic [EW-1:0] head;
    logic          unused_ok;

    // rx_busy is status only; nothing in the sequencing depends on it.
    assign unused_ok = rx_busy;

    assign rx_en     = en;
    assign capture   = en && (state == CAPTURE);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

`ifdef RX_CTRL_KEEP_ERR_EN
    assign push      = capture && (!full || pop);
    assign push_data = {rx_error, rx_po};
    assign out_data  = head[WIDTH-1:0];
    assign out_err   = head[WIDTH];
`else
    assign push      = capture && !rx_error && (!full || pop);
    assign push_data = rx_po;
    assign out_data  = head;
`endif

    rx_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT;
            rx_data_ack <= 1'b0;
            err_count   <= '0;
            overflow    <= 1'b0;
        end else if (!en) begin
            state       <= WAIT;
            rx_data_ack <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    rx_data_ack <= 1'b0;
                    if (rx_ready) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (rx_error) begin
                        err_count <= ERR_CNT_W'(sat_inc(32'(err_count), ERR_CNT_W));
                    end else if (full && !pop) begin
                        overflow <= 1'b1;
                    end
                    rx_data_ack <= 1'b1;
                    state       <= ACK;
                end
                ACK: begin
                    rx_data_ack <= 1'b0;
                    state       <= RELEASE;
                end
                RELEASE: begin
                    // The receiver drops rx_ready a cycle after the ack; waiting
                    // for it here keeps one frame from being captured twice.
                    rx_data_ack <= 1'b0;
                    if (!rx_ready) begin
                        state <= WAIT;
                    end
                end
                default: begin
                    rx_data_ack <= 1'b0;
                    state       <= WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_ctrl.sv
// tb/tb_rx_ctrl.sv - directed self-checking bench for rx_ctrl
module tb_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       rx_en;
    logic       rx_ready = 1'b0;
    logic       rx_error = 1'b0;
    logic [7:0] rx_po = 8'h00;
    logic       rx_busy = 1'b0;
    logic       rx_data_ack;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] fifo_count;
    logic [7:0] err_count;
    logic       overflow;
`ifdef RX_CTRL_KEEP_ERR_EN
    logic       out_err;
`endif

    int checks = 0;
    int errors = 0;

    rx_ctrl #(.WIDTH(8), .DEPTH(4), .ERR_CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .rx_en       (rx_en),
        .rx_ready    (rx_ready),
        .rx_error    (rx_error),
        .rx_po       (rx_po),
        .rx_busy     (rx_busy),
        .rx_data_ack (rx_data_ack),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .err_count   (err_count),
        .overflow    (overflow)
`ifdef RX_CTRL_KEEP_ERR_EN
        ,
        .out_err     (out_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receiver model: raise rx_ready with the byte, expect the ack two edges
    // later, keep rx_ready high for 'extra' cycles after the ack, then drop it.
    // pop_at_cap pulses out_ready in the cycle the byte is captured.
    task automatic frame(input logic [7:0] d, input logic e, input int extra, input logic pop_at_cap);
        rx_po    = d;
        rx_error = e;
        rx_ready = 1'b1;
        tick();
        out_ready = pop_at_cap;
        tick();
        out_ready = 1'b0;
        chk("ack_high", 32'(rx_data_ack), 1);
        tick();
        chk("ack_low", 32'(rx_data_ack), 0);
        repeat (extra) tick();
        rx_ready = 1'b0;
        rx_error = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ack", 32'(rx_data_ack), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rx_en_hi", 32'(rx_en), 1);
        en = 1'b0;
        #1;
        chk("rx_en_lo", 32'(rx_en), 0);
        en = 1'b1;

        // Good frame 0xA5: latency and buffering
        rx_po    = 8'hA5;
        rx_ready = 1'b1;
        tick();
        chk("a5_ack_e1", 32'(rx_data_ack), 0);
        chk("a5_valid_e1", 32'(out_valid), 0);
        tick();
        chk("a5_ack_e2", 32'(rx_data_ack), 1);
        chk("a5_valid_e2", 32'(out_valid), 1);
        chk("a5_data", 32'(out_data), 32'hA5);
        chk("a5_count", 32'(fifo_count), 1);
        tick();
        chk("a5_ack_e3", 32'(rx_data_ack), 0);
        rx_ready = 1'b0;
        tick();
        tick();
        pop_one();
        chk("a5_pop_count", 32'(fifo_count), 0);
        chk("a5_pop_valid", 32'(out_valid), 0);
        chk("a5_hold", 32'(out_data), 32'hA5);
        pop_one();
        chk("empty_pop", 32'(fifo_count), 0);

        // Errored frame 0x3C
        frame(8'h3C, 1'b1, 0, 1'b0);
        chk("err_cnt1", 32'(err_count), 1);
`ifdef RX_CTRL_KEEP_ERR_EN
        chk("err_kept_count", 32'(fifo_count), 1);
        chk("err_kept_flag", 32'(out_err), 1);
        chk("err_kept_data", 32'(out_data), 32'h3C);
        pop_one();
`else
        chk("err_drop_count", 32'(fifo_count), 0);
`endif

        // Five frames into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0, 0, 1'b0);
        chk("fill_count", 32'(fifo_count), 4);
        chk("fill_ovf", 32'(overflow), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("fill_order", 32'(out_data), 32'(i));
            pop_one();
        end
        chk("drain_count", 32'(fifo_count), 0);

        // Full FIFO with a pop in the capture cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_ovf", 32'(overflow), 0);
        chk("rst2_err", 32'(err_count), 0);
        for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 1'b0, 0, 1'b0);
        chk("full_count", 32'(fifo_count), 4);
        frame(8'h14, 1'b0, 0, 1'b1);
        chk("pushpop_count", 32'(fifo_count), 4);
        chk("pushpop_ovf", 32'(overflow), 0);
        for (int i = 1; i <= 4; i++) begin
            chk("pushpop_order", 32'(out_data), 32'h10 + 32'(i));
            pop_one();
        end

        // rx_ready held high after the ack
        rx_po    = 8'h77;
        rx_ready = 1'b1;
        tick();
        tick();
        chk("hold_ack", 32'(rx_data_ack), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_no_ack", 32'(rx_data_ack), 0);
            chk("hold_count", 32'(fifo_count), 1);
        end
        rx_ready = 1'b0;
        tick();
        tick();
        chk("hold_final", 32'(fifo_count), 1);
        chk("hold_data", 32'(out_data), 32'h77);

        // en=0: no capture, pops still honoured
        en       = 1'b0;
        rx_po    = 8'h99;
        rx_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("dis_ack", 32'(rx_data_ack), 0);
        chk("dis_count", 32'(fifo_count), 1);
        pop_one();
        chk("dis_pop", 32'(fifo_count), 0);
        en = 1'b1;
        tick();
        tick();
        chk("reen_ack", 32'(rx_data_ack), 1);
        chk("reen_data", 32'(out_data), 32'h99);
        rx_ready = 1'b0;
        tick();
        tick();
        pop_one();

        // Error counter saturation
        for (int i = 0; i < 255; i++) frame(8'h3C, 1'b1, 0, 1'b0);
        chk("err_255", 32'(err_count), 32'hFF);
        frame(8'h3C, 1'b1, 0, 1'b0);
        chk("err_sat", 32'(err_count), 32'hFF);

        // Reset during ACK
        rx_po    = 8'h5A;
        rx_ready = 1'b1;
        tick();
        tick();
        chk("rst_ack_pre", 32'(rx_data_ack), 1);
        rst      = 1'b1;
        rx_ready = 1'b0;
        tick();
        chk("rst_ack_abort", 32'(rx_data_ack), 0);
        chk("rst_ack_count", 32'(fifo_count), 0);
        chk("rst_ack_err", 32'(err_count), 0);
        chk("rst_ack_valid", 32'(out_valid), 0);
        rst = 1'b0;
        tick();
        frame(8'hC3, 1'b0, 0, 1'b0);
        chk("recover_count", 32'(fifo_count), 1);
        chk("recover_data", 32'(out_data), 32'hC3);
`ifdef RX_CTRL_KEEP_ERR_EN
        chk("recover_flag", 32'(out_err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
